// File: rtl/pll_rst_seq_if.sv
// rtl/pll_rst_seq_if.sv - PLL lock input and reset/status outputs of the reset sequencer
interface pll_rst_seq_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output retry_cnt,
        output lock_lost_cnt
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  retry_cnt,
        input  lock_lost_cnt
    );
endinterface

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset pulse, lock qualification and system reset release
// Define PLL_RST_SEQ_RETRY_EN to re-pulse the PLL after a lock timeout and count retries.
module pll_rst_seq #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 1024
) (
    input  logic          refclk,
    input  logic          rst_n,
    pll_rst_seq_if.master bus
);

    localparam int RST_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam int STB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);

    if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE_CYCLES < 1) begin : g_param_check
        $error("pll_rst_seq: cycle parameters must be at least 1");
    end

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         rst_sync_q;
    logic               lock_meta_q, lock_s_q;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [7:0]         lost_q, lost_d;
    logic               pll_rst_q, sys_rst_n_q, ready_q;
    logic               run_en;

`ifdef PLL_RST_SEQ_RETRY_EN
    localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [7:0]         retry_q, retry_d;
`endif

    // Reset asserts asynchronously but is released only after two refclk edges.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign run_en = rst_sync_q[1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= bus.pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stb_cnt_d = stb_cnt_q;
        lost_d    = lost_q;
`ifdef PLL_RST_SEQ_RETRY_EN
        to_cnt_d  = to_cnt_q;
        retry_d   = retry_q;
`endif
        case (state_q)
            PLL_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lock_s_q) begin
                    state_d = STABLE;
                end
`ifdef PLL_RST_SEQ_RETRY_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = PLL_RST;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            STABLE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (stb_cnt_q == STB_LAST) begin
                    state_d = RUN;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d = PLL_RST;
                    if (lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                end
            end
            default: state_d = PLL_RST;
        endcase

        if (!run_en) begin
            state_d = PLL_RST;
        end

        // Every state entry starts its counters from zero.
        if (state_d != state_q || !run_en) begin
            rst_cnt_d = '0;
            stb_cnt_d = '0;
`ifdef PLL_RST_SEQ_RETRY_EN
            to_cnt_d  = '0;
`endif
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            rst_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            lost_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            lost_q      <= lost_d;
            pll_rst_q   <= (state_d == PLL_RST);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

`ifdef PLL_RST_SEQ_RETRY_EN
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            retry_q  <= 8'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
            retry_q  <= retry_d;
        end
    end
    assign bus.retry_cnt = retry_q;
`else
    assign bus.retry_cnt = 8'd0;
`endif

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.ready         = ready_q;
    assign bus.lock_lost_cnt = lost_q;

endmodule
